apb_timeout_bridge: RTL and testbench
=====================================

// Module: apb_timeout_bridge
// PURPOSE
//  APB pass-through stage directly downstream of the QSPI management bridge's APB requester port, in front of the chip APB fabric.
//  Re-times each transfer, forwards it, and bounds its duration.
//  A completer that never asserts pready is aborted after TIMEOUT_CYCLES; the bridge then completes upstream with pslverr=1 and prdata=ERR_PATTERN.
//  A hung peripheral therefore cannot wedge the MCU management path.
// PARAMETERS
//  DATA_WIDTH      16        APB data width, both sides
//  ADDR_WIDTH      24        APB address width, both sides
//  TIMEOUT_CYCLES  1024      downstream ACCESS cycles allowed before abort (>=2)
//  ERR_PATTERN     'hDEAD    prdata returned upstream on timeout (truncated to DATA_WIDTH)
// PORTS
//  clk                input   1    single clock; both APB sides run on it
//  rst_n              input   1    reset: synchronous, active-low
//  up                 APB.completer  -   faces the management bridge (paddr/pwdata/pstrb/pwrite/psel/penable in; pready/prdata/pslverr out)
//  dn                 APB.requester  -   faces the APB fabric; dn.pclk=clk, dn.preset_n=rst_n
//  timeout_pulse      output  1    one-cycle strobe on each abort
//  timeout_count      output  16   aborts since reset, saturates at 16'hFFFF
//  last_timeout_addr  output  ADDR_WIDTH  paddr of most recent abort
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=IDLE; all up/dn outputs 0; counter, timeout_count and last_timeout_addr 0. Applies mid-transfer: dn.psel drops next cycle, and no up response is issued for the aborted transfer.
//  States: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//  IDLE:   up.psel=1 at an edge -> latch paddr/pwdata/pstrb/pwrite/pprot; go SETUP. up.penable is not required to accept.
//  SETUP:  dn.psel=1, dn.penable=0, latched fields driven; counter cleared; -> ACCESS.
//  ACCESS: dn.psel=1, dn.penable=1; counter++ each cycle.
//    dn.pready=1 -> capture dn.prdata/dn.pslverr; -> RESP.
//    counter==TIMEOUT_CYCLES-1 with dn.pready=0 -> dn.psel/penable=0 next cycle; response = {ERR_PATTERN, pslverr=1}; timeout_pulse=1; -> RESP.
//    pready and timeout in the same cycle: pready wins; no timeout is logged.
//  RESP:   up.pready=1 for exactly one cycle with captured prdata/pslverr; dn idle; -> IDLE.
//    up.prdata=0 for writes; outside RESP, up.pready/prdata/pslverr=0.
//  Latency: up.psel sampled at edge T0 -> dn setup T1 -> dn access T2 -> up.pready at T3 earliest (zero-wait completer). Fixed 2 added cycles vs a direct connection.
//  Back-to-back: a new up.psel is accepted only in IDLE, one cycle after RESP. Upstream holds psel across RESP per APB, so no request is lost.
//  dn.pready while dn.psel=0 (late reply after abort) is ignored.
//  Counter width: $clog2(TIMEOUT_CYCLES)+1; it never wraps inside a transfer.
//  timeout_count saturates; no wrap to 0.
// CONFIGURATION
//  Macro APB_TIMEOUT_BRIDGE_LOG_EN:
//    defined   -> timeout_count and last_timeout_addr update on each abort (same edge as timeout_pulse).
//    undefined -> both ports tied to 0 and their registers removed. timeout_pulse and abort behaviour are unchanged.
// STRUCTURE
//  Shared package apb_bridge_pkg: typedef enum logic[1:0] {BR_IDLE, BR_SETUP, BR_ACCESS, BR_RESP} bridge_state_t; localparam APB_ERR_PATTERN_DEFAULT='hDEAD.
//  One sub-module, apb_txn_timer: clear/enable counter with an expired output, parameterised by TIMEOUT_CYCLES.
//  The state machine and datapath latches stay in the top module.
// TESTING
//  1 Write 0x1234 to 0x000010, dn.pready tied 1 -> dn sees psel/penable at T1/T2 with pwdata 0x1234; up.pready at T3, pslverr=0.
//  2 Read 0x000020, completer waits 5 cycles then returns 0xBEEF -> up.prdata=0xBEEF, pslverr=0, up.pready one cycle after dn.pready.
//  3 Read 0x000040, dn.pready held 0, TIMEOUT_CYCLES=16 -> dn.psel drops after 16 ACCESS cycles; up.prdata=0xDEAD, pslverr=1; timeout_pulse single cycle; timeout_count=1, last_timeout_addr=0x000040 (LOG_EN) or both 0 (undefined).
//  4 dn.pready asserted on the exact cycle counter hits 15 (TIMEOUT_CYCLES=16) -> normal completion, no pulse, count unchanged.
//  5 rst_n=0 during ACCESS -> next cycle dn.psel=0, up.pready=0, state IDLE. After release, a write completes normally; the stale late dn.pready is ignored.
//  6 Force 65536 timeouts (or preload) then one more -> timeout_count stays 0xFFFF.

Source files
------------

// File: rtl/apb_bridge_pkg.sv
// Shared definitions for the APB timeout bridge.
//  bridge_state_t          : bridge FSM states
//  APB_ERR_PATTERN_DEFAULT : default read data returned upstream on an aborted transfer
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    BR_IDLE,
    BR_SETUP,
    BR_ACCESS,
    BR_RESP
  } bridge_state_t;

  localparam logic [31:0] APB_ERR_PATTERN_DEFAULT = 32'hDEAD;

  localparam int unsigned APB_PROT_WIDTH = 3;
  localparam int unsigned TIMEOUT_COUNT_WIDTH = 16;

endpackage

// File: rtl/apb_txn_timer.sv
// Transfer duration timer for the APB timeout bridge.
// Ports:
//  clk, rst_n  : clock, synchronous active-low reset
//  clear_i     : force the count to zero (takes priority over enable_i)
//  enable_i    : advance the count by one this cycle
//  expired_o   : count has reached TIMEOUT_CYCLES-1
// The count holds at TIMEOUT_CYCLES-1 rather than wrapping.
module apb_txn_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT_CYCLES - 1);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_timeout_bridge.sv
// APB pass-through stage that re-times each transfer and aborts it if the downstream
// completer does not answer within TIMEOUT_CYCLES access cycles. An aborted transfer
// completes upstream with pslverr=1 and prdata=ERR_PATTERN.
// Ports:
//  clk, rst_n          : single clock, synchronous active-low reset
//  up_*                : APB completer side (towards the management bridge)
//  dn_*                : APB requester side (towards the APB fabric)
//  timeout_pulse       : one-cycle strobe per abort (high during the abort's response cycle)
//  timeout_count       : saturating abort count
//  last_timeout_addr   : address of the most recent aborted transfer
// Build option: define APB_TIMEOUT_BRIDGE_LOG_EN to enable timeout_count and
// last_timeout_addr; without it both are tied to zero.
module apb_timeout_bridge
  import apb_bridge_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 24,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_PATTERN    = APB_ERR_PATTERN_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  // Upstream completer port
  input  logic [ADDR_WIDTH-1:0]          up_paddr_i,
  input  logic [DATA_WIDTH-1:0]          up_pwdata_i,
  input  logic [DATA_WIDTH/8-1:0]        up_pstrb_i,
  input  logic                           up_pwrite_i,
  input  logic [APB_PROT_WIDTH-1:0]      up_pprot_i,
  input  logic                           up_psel_i,
  input  logic                           up_penable_i,
  output logic                           up_pready_o,
  output logic [DATA_WIDTH-1:0]          up_prdata_o,
  output logic                           up_pslverr_o,
  // Downstream requester port
  output logic [ADDR_WIDTH-1:0]          dn_paddr_o,
  output logic [DATA_WIDTH-1:0]          dn_pwdata_o,
  output logic [DATA_WIDTH/8-1:0]        dn_pstrb_o,
  output logic                           dn_pwrite_o,
  output logic [APB_PROT_WIDTH-1:0]      dn_pprot_o,
  output logic                           dn_psel_o,
  output logic                           dn_penable_o,
  input  logic                           dn_pready_i,
  input  logic [DATA_WIDTH-1:0]          dn_prdata_i,
  input  logic                           dn_pslverr_i,
  // Timeout reporting
  output logic                           timeout_pulse,
  output logic [TIMEOUT_COUNT_WIDTH-1:0] timeout_count,
  output logic [ADDR_WIDTH-1:0]          last_timeout_addr
);

  localparam int unsigned StrbWidth = DATA_WIDTH / 8;
  localparam logic [DATA_WIDTH-1:0] ErrData = DATA_WIDTH'(ERR_PATTERN);

  bridge_state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0]     paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]     pwdata_q, pwdata_d;
  logic [StrbWidth-1:0]      pstrb_q, pstrb_d;
  logic                      pwrite_q, pwrite_d;
  logic [APB_PROT_WIDTH-1:0] pprot_q, pprot_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      slverr_q, slverr_d;
  logic                      pulse_q, pulse_d;

  logic timer_clear, timer_en, timer_expired;
  logic dn_active;

  // Setup is accepted on psel alone, so penable carries no information here.
  logic unused_up_penable;
  assign unused_up_penable = up_penable_i;

  apb_txn_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (timer_clear),
    .enable_i (timer_en),
    .expired_o(timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    pwrite_d    = pwrite_q;
    pprot_d     = pprot_q;
    rdata_d     = rdata_q;
    slverr_d    = slverr_q;
    pulse_d     = 1'b0;
    timer_clear = 1'b0;
    timer_en    = 1'b0;

    unique case (state_q)
      BR_IDLE: begin
        if (up_psel_i) begin
          paddr_d  = up_paddr_i;
          pwdata_d = up_pwdata_i;
          pstrb_d  = up_pstrb_i;
          pwrite_d = up_pwrite_i;
          pprot_d  = up_pprot_i;
          state_d  = BR_SETUP;
        end
      end
      BR_SETUP: begin
        timer_clear = 1'b1;
        state_d     = BR_ACCESS;
      end
      BR_ACCESS: begin
        timer_en = 1'b1;
        // A reply on the final allowed cycle still counts as a normal completion.
        if (dn_pready_i) begin
          rdata_d  = dn_prdata_i;
          slverr_d = dn_pslverr_i;
          state_d  = BR_RESP;
        end else if (timer_expired) begin
          rdata_d  = ErrData;
          slverr_d = 1'b1;
          pulse_d  = 1'b1;
          state_d  = BR_RESP;
        end
      end
      BR_RESP: begin
        state_d = BR_IDLE;
      end
      default: begin
        state_d = BR_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= BR_IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      pwrite_q <= 1'b0;
      pprot_q  <= '0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      pwrite_q <= pwrite_d;
      pprot_q  <= pprot_d;
      rdata_q  <= rdata_d;
      slverr_q <= slverr_d;
      pulse_q  <= pulse_d;
    end
  end

  // Downstream: request fields are only driven while a transfer is on the bus.
  assign dn_active    = (state_q == BR_SETUP) || (state_q == BR_ACCESS);
  assign dn_psel_o    = dn_active;
  assign dn_penable_o = (state_q == BR_ACCESS);
  assign dn_paddr_o   = dn_active ? paddr_q  : '0;
  assign dn_pwdata_o  = dn_active ? pwdata_q : '0;
  assign dn_pstrb_o   = dn_active ? pstrb_q  : '0;
  assign dn_pwrite_o  = dn_active & pwrite_q;
  assign dn_pprot_o   = dn_active ? pprot_q  : '0;

  // Upstream response exists only in RESP; writes never return read data.
  assign up_pready_o  = (state_q == BR_RESP);
  assign up_prdata_o  = (up_pready_o && !pwrite_q) ? rdata_q : '0;
  assign up_pslverr_o = up_pready_o & slverr_q;

  assign timeout_pulse = pulse_q;

`ifdef APB_TIMEOUT_BRIDGE_LOG_EN
  logic [TIMEOUT_COUNT_WIDTH-1:0] timeout_count_q, timeout_count_d;
  logic [ADDR_WIDTH-1:0]          last_addr_q, last_addr_d;

  always_comb begin
    timeout_count_d = timeout_count_q;
    last_addr_d     = last_addr_q;
    if (pulse_d) begin
      last_addr_d = paddr_q;
      if (timeout_count_q != '1) begin
        timeout_count_d = timeout_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timeout_count_q <= '0;
      last_addr_q     <= '0;
    end else begin
      timeout_count_q <= timeout_count_d;
      last_addr_q     <= last_addr_d;
    end
  end

  assign timeout_count     = timeout_count_q;
  assign last_timeout_addr = last_addr_q;
`else
  assign timeout_count     = '0;
  assign last_timeout_addr = '0;
`endif

endmodule

// File: tb/tb_apb_timeout_bridge.sv
// Directed self-checking bench for apb_timeout_bridge (TIMEOUT_CYCLES=16).
module tb_apb_timeout_bridge;

  localparam int unsigned AW = 24;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 16;
`ifdef APB_TIMEOUT_BRIDGE_LOG_EN
  localparam bit LogEn = 1'b1;
`else
  localparam bit LogEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] up_paddr_i = '0;
  logic [DW-1:0] up_pwdata_i = '0;
  logic [1:0]    up_pstrb_i = '0;
  logic          up_pwrite_i = 1'b0;
  logic [2:0]    up_pprot_i = '0;
  logic          up_psel_i = 1'b0;
  logic          up_penable_i = 1'b0;
  logic          up_pready_o;
  logic [DW-1:0] up_prdata_o;
  logic          up_pslverr_o;
  logic [AW-1:0] dn_paddr_o;
  logic [DW-1:0] dn_pwdata_o;
  logic [1:0]    dn_pstrb_o;
  logic          dn_pwrite_o;
  logic [2:0]    dn_pprot_o;
  logic          dn_psel_o;
  logic          dn_penable_o;
  logic          dn_pready_i = 1'b0;
  logic [DW-1:0] dn_prdata_i = '0;
  logic          dn_pslverr_i = 1'b0;
  logic          timeout_pulse;
  logic [15:0]   timeout_count;
  logic [AW-1:0] last_timeout_addr;

  int checks = 0;
  int errors = 0;

  apb_timeout_bridge #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TO),
    .ERR_PATTERN   (32'hDEAD)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .up_paddr_i       (up_paddr_i),
    .up_pwdata_i      (up_pwdata_i),
    .up_pstrb_i       (up_pstrb_i),
    .up_pwrite_i      (up_pwrite_i),
    .up_pprot_i       (up_pprot_i),
    .up_psel_i        (up_psel_i),
    .up_penable_i     (up_penable_i),
    .up_pready_o      (up_pready_o),
    .up_prdata_o      (up_prdata_o),
    .up_pslverr_o     (up_pslverr_o),
    .dn_paddr_o       (dn_paddr_o),
    .dn_pwdata_o      (dn_pwdata_o),
    .dn_pstrb_o       (dn_pstrb_o),
    .dn_pwrite_o      (dn_pwrite_o),
    .dn_pprot_o       (dn_pprot_o),
    .dn_psel_o        (dn_psel_o),
    .dn_penable_o     (dn_penable_o),
    .dn_pready_i      (dn_pready_i),
    .dn_prdata_i      (dn_prdata_i),
    .dn_pslverr_i     (dn_pslverr_i),
    .timeout_pulse    (timeout_pulse),
    .timeout_count    (timeout_count),
    .last_timeout_addr(last_timeout_addr)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Runs one upstream transfer. wait_n = access cycles with pready low before the reply
  // (-1 = never reply). edges counts clock edges from the SETUP state to the RESP state.
  task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int wait_n, input logic [DW-1:0] rdata, input logic slv,
                         output logic [DW-1:0] got_rdata, output logic got_err,
                         output int acc, output int edges, output int pulses,
                         output logic dn_busy_resp, output logic done);
    done = 1'b0; acc = 0; edges = 0; pulses = 0;
    got_rdata = '0; got_err = 1'b0; dn_busy_resp = 1'b0;
    up_paddr_i = addr; up_pwdata_i = wdata; up_pwrite_i = wr;
    up_pstrb_i = 2'b11; up_pprot_i = 3'b010;
    up_psel_i = 1'b1; up_penable_i = 1'b0;
    dn_pready_i = 1'b0; dn_pslverr_i = 1'b0;
    cyc();
    up_penable_i = 1'b1;
    while (edges < 200) begin
      if (dn_psel_o && dn_penable_o) begin
        dn_pready_i  = (wait_n >= 0) && (acc == wait_n);
        dn_prdata_i  = rdata;
        dn_pslverr_i = slv;
        acc++;
      end else begin
        dn_pready_i  = 1'b0;
        dn_pslverr_i = 1'b0;
      end
      cyc();
      edges++;
      if (timeout_pulse) pulses++;
      if (up_pready_o) begin
        got_rdata    = up_prdata_o;
        got_err      = up_pslverr_o;
        dn_busy_resp = dn_psel_o;
        done         = 1'b1;
        break;
      end
    end
    dn_pready_i = 1'b0; dn_pslverr_i = 1'b0;
    up_psel_i = 1'b0; up_penable_i = 1'b0;
    cyc();
    if (timeout_pulse) pulses++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    up_psel_i = 1'b1;
    dn_pready_i = 1'b1;
    repeat (3) cyc();
    checks++;
    if ({up_pready_o, up_pslverr_o, up_prdata_o} !== '0) begin
      errors++;
      $display("FAIL reset_up: got rdy=%b err=%b rdata=%h, want all 0",
               up_pready_o, up_pslverr_o, up_prdata_o);
    end
    checks++;
    if ({dn_psel_o, dn_penable_o, dn_paddr_o, dn_pwdata_o} !== '0) begin
      errors++;
      $display("FAIL reset_dn: got psel=%b pen=%b addr=%h wdata=%h, want all 0",
               dn_psel_o, dn_penable_o, dn_paddr_o, dn_pwdata_o);
    end
    checks++;
    if ({timeout_pulse, timeout_count, last_timeout_addr} !== '0) begin
      errors++;
      $display("FAIL reset_log: got pulse=%b count=%h addr=%h, want all 0",
               timeout_pulse, timeout_count, last_timeout_addr);
    end
    up_psel_i = 1'b0;
    dn_pready_i = 1'b0;
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_write_zero_wait();
    up_paddr_i = 24'h000010; up_pwdata_i = 16'h1234; up_pwrite_i = 1'b1;
    up_pstrb_i = 2'b11; up_pprot_i = 3'b001;
    up_psel_i = 1'b1; up_penable_i = 1'b0;
    dn_pready_i = 1'b1;
    cyc();
    checks++;
    if ({dn_psel_o, dn_penable_o, dn_pwrite_o} !== 3'b101 || dn_paddr_o !== 24'h000010 ||
        dn_pwdata_o !== 16'h1234 || dn_pstrb_o !== 2'b11 || dn_pprot_o !== 3'b001) begin
      errors++;
      $display("FAIL wr_setup: got sel/en/wr=%b%b%b addr=%h wdata=%h strb=%b prot=%b, want 101 000010 1234 11 001",
               dn_psel_o, dn_penable_o, dn_pwrite_o, dn_paddr_o, dn_pwdata_o, dn_pstrb_o, dn_pprot_o);
    end
    up_penable_i = 1'b1;
    cyc();
    checks++;
    if ({dn_psel_o, dn_penable_o, up_pready_o} !== 3'b110) begin
      errors++;
      $display("FAIL wr_access: got sel/en/up_rdy=%b%b%b, want 110",
               dn_psel_o, dn_penable_o, up_pready_o);
    end
    cyc();
    checks++;
    if ({up_pready_o, up_pslverr_o, dn_psel_o} !== 3'b100 || up_prdata_o !== 16'h0000) begin
      errors++;
      $display("FAIL wr_resp: got rdy/err/dn_sel=%b%b%b rdata=%h, want 100 0000",
               up_pready_o, up_pslverr_o, dn_psel_o, up_prdata_o);
    end
    up_psel_i = 1'b0; up_penable_i = 1'b0; dn_pready_i = 1'b0;
    cyc();
    checks++;
    if (up_pready_o !== 1'b0) begin
      errors++;
      $display("FAIL wr_one_cycle: got up_pready=%b, want 0", up_pready_o);
    end
  endtask

  task automatic test_read_wait();
    logic [DW-1:0] rd; logic er, busy, done; int acc, edges, pulses;
    run_txn(1'b0, 24'h000020, '0, 5, 16'hBEEF, 1'b0, rd, er, acc, edges, pulses, busy, done);
    checks++;
    if (!done || rd !== 16'hBEEF || er !== 1'b0) begin
      errors++;
      $display("FAIL rd_wait_data: got done=%b rdata=%h err=%b, want 1 BEEF 0", done, rd, er);
    end
    checks++;
    if (acc != 6 || edges != 7 || pulses != 0) begin
      errors++;
      $display("FAIL rd_wait_timing: got acc=%0d edges=%0d pulses=%0d, want 6 7 0",
               acc, edges, pulses);
    end
  endtask

  task automatic test_read_slverr();
    logic [DW-1:0] rd; logic er, busy, done; int acc, edges, pulses;
    run_txn(1'b0, 24'h000030, '0, 0, 16'h5A5A, 1'b1, rd, er, acc, edges, pulses, busy, done);
    checks++;
    if (!done || rd !== 16'h5A5A || er !== 1'b1 || edges != 2 || pulses != 0) begin
      errors++;
      $display("FAIL rd_slverr: got done=%b rdata=%h err=%b edges=%0d pulses=%0d, want 1 5A5A 1 2 0",
               done, rd, er, edges, pulses);
    end
  endtask

  task automatic test_timeout();
    logic [DW-1:0] rd; logic er, busy, done; int acc, edges, pulses;
    run_txn(1'b0, 24'h000040, '0, -1, 16'h1111, 1'b0, rd, er, acc, edges, pulses, busy, done);
    checks++;
    if (!done || rd !== 16'hDEAD || er !== 1'b1) begin
      errors++;
      $display("FAIL to_resp: got done=%b rdata=%h err=%b, want 1 DEAD 1", done, rd, er);
    end
    checks++;
    if (acc != 16 || edges != 17 || busy !== 1'b0) begin
      errors++;
      $display("FAIL to_timing: got acc=%0d edges=%0d dn_sel_at_resp=%b, want 16 17 0",
               acc, edges, busy);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL to_pulse: got %0d pulse cycles, want 1", pulses);
    end
    checks++;
    if (timeout_count !== (LogEn ? 16'd1 : 16'd0) ||
        last_timeout_addr !== (LogEn ? 24'h000040 : 24'h0)) begin
      errors++;
      $display("FAIL to_log: got count=%h addr=%h, want %h %h", timeout_count,
               last_timeout_addr, LogEn ? 16'd1 : 16'd0, LogEn ? 24'h000040 : 24'h0);
    end
  endtask

  task automatic test_pready_on_limit();
    logic [DW-1:0] rd; logic er, busy, done; int acc, edges, pulses;
    run_txn(1'b0, 24'h000050, '0, 15, 16'h1357, 1'b0, rd, er, acc, edges, pulses, busy, done);
    checks++;
    if (!done || rd !== 16'h1357 || er !== 1'b0 || acc != 16 || pulses != 0) begin
      errors++;
      $display("FAIL limit_resp: got done=%b rdata=%h err=%b acc=%0d pulses=%0d, want 1 1357 0 16 0",
               done, rd, er, acc, pulses);
    end
    checks++;
    if (timeout_count !== (LogEn ? 16'd1 : 16'd0) ||
        last_timeout_addr !== (LogEn ? 24'h000040 : 24'h0)) begin
      errors++;
      $display("FAIL limit_log: got count=%h addr=%h, want unchanged", timeout_count,
               last_timeout_addr);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] rd; logic er, busy, done; int acc, edges, pulses;
    up_paddr_i = 24'h000060; up_pwrite_i = 1'b0; up_psel_i = 1'b1; up_penable_i = 1'b0;
    dn_pready_i = 1'b0;
    cyc();
    up_penable_i = 1'b1;
    repeat (3) cyc();
    checks++;
    if ({dn_psel_o, dn_penable_o} !== 2'b11) begin
      errors++;
      $display("FAIL rstmid_pre: got sel/en=%b%b, want 11", dn_psel_o, dn_penable_o);
    end
    rst_n = 1'b0;
    cyc();
    checks++;
    if ({dn_psel_o, dn_penable_o, up_pready_o} !== 3'b000) begin
      errors++;
      $display("FAIL rstmid_abort: got sel/en/up_rdy=%b%b%b, want 000",
               dn_psel_o, dn_penable_o, up_pready_o);
    end
    up_psel_i = 1'b0; up_penable_i = 1'b0;
    dn_pready_i = 1'b1;
    cyc();
    rst_n = 1'b1;
    repeat (2) cyc();
    checks++;
    if ({dn_psel_o, up_pready_o, timeout_pulse} !== 3'b000 || timeout_count !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_stale: got dn_sel/up_rdy/pulse=%b%b%b count=%h, want 000 0000",
               dn_psel_o, up_pready_o, timeout_pulse, timeout_count);
    end
    dn_pready_i = 1'b0;
    run_txn(1'b1, 24'h000070, 16'hCAFE, 0, 16'hFFFF, 1'b0, rd, er, acc, edges, pulses, busy,
            done);
    checks++;
    if (!done || rd !== 16'h0000 || er !== 1'b0 || edges != 2) begin
      errors++;
      $display("FAIL rstmid_after: got done=%b rdata=%h err=%b edges=%0d, want 1 0000 0 2",
               done, rd, er, edges);
    end
  endtask

  task automatic test_back_to_back();
    up_paddr_i = 24'h000080; up_pwrite_i = 1'b0; up_psel_i = 1'b1; up_penable_i = 1'b0;
    dn_pready_i = 1'b1; dn_prdata_i = 16'h0A0A;
    cyc();
    up_penable_i = 1'b1;
    repeat (2) cyc();
    // Response cycle: present the next request immediately.
    up_paddr_i = 24'h000090; up_penable_i = 1'b0;
    cyc();
    checks++;
    if ({dn_psel_o, up_pready_o} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_idle: got dn_sel/up_rdy=%b%b, want 00", dn_psel_o, up_pready_o);
    end
    cyc();
    checks++;
    if (dn_psel_o !== 1'b1 || dn_penable_o !== 1'b0 || dn_paddr_o !== 24'h000090) begin
      errors++;
      $display("FAIL b2b_second: got sel=%b en=%b addr=%h, want 1 0 000090",
               dn_psel_o, dn_penable_o, dn_paddr_o);
    end
    up_penable_i = 1'b1;
    repeat (2) cyc();
    checks++;
    if (up_pready_o !== 1'b1 || up_prdata_o !== 16'h0A0A) begin
      errors++;
      $display("FAIL b2b_resp: got rdy=%b rdata=%h, want 1 0A0A", up_pready_o, up_prdata_o);
    end
    up_psel_i = 1'b0; up_penable_i = 1'b0; dn_pready_i = 1'b0;
    cyc();
  endtask

  task automatic test_saturation();
    logic [DW-1:0] rd; logic er, busy, done; int acc, edges, pulses;
`ifdef APB_TIMEOUT_BRIDGE_LOG_EN
    force dut.timeout_count_q = 16'hFFFE;
    cyc();
    release dut.timeout_count_q;
    cyc();
    checks++;
    if (timeout_count !== 16'hFFFE) begin
      errors++;
      $display("FAIL sat_preload: got %h, want FFFE", timeout_count);
    end
`endif
    run_txn(1'b0, 24'h0000A0, '0, -1, '0, 1'b0, rd, er, acc, edges, pulses, busy, done);
    checks++;
    if (timeout_count !== (LogEn ? 16'hFFFF : 16'h0) ||
        last_timeout_addr !== (LogEn ? 24'h0000A0 : 24'h0)) begin
      errors++;
      $display("FAIL sat_first: got count=%h addr=%h", timeout_count, last_timeout_addr);
    end
    run_txn(1'b0, 24'h0000B0, '0, -1, '0, 1'b0, rd, er, acc, edges, pulses, busy, done);
    checks++;
    if (timeout_count !== (LogEn ? 16'hFFFF : 16'h0) ||
        last_timeout_addr !== (LogEn ? 24'h0000B0 : 24'h0) || pulses != 1 || rd !== 16'hDEAD) begin
      errors++;
      $display("FAIL sat_hold: got count=%h addr=%h pulses=%0d rdata=%h",
               timeout_count, last_timeout_addr, pulses, rd);
    end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_read_slverr();
    test_timeout();
    test_pready_on_limit();
    test_reset_mid();
    test_back_to_back();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
